// File: rtl/in_chunks_pkg.sv
// Shared constants and helpers for the nibble-stream word assembler.
package in_chunks_pkg;

    localparam int unsigned CHUNK_W    = 4;
    localparam int unsigned WORD_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 4;

    typedef logic [CHUNK_W-1:0] chunk_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/in_chunks_if.sv
// Chunk input stream and assembled-word output handshake of in_chunks.
interface in_chunks_if
    import in_chunks_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF
);

    logic              in_valid;
    chunk_t            in_bits;
    logic              in_last;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_last;
    logic              word_ready;

    // master is the environment: chunk producer and word consumer
    modport master (
        output in_valid, in_bits, in_last, word_ready,
        input  word_valid, word_data, word_last
    );

    modport slave (
        input  in_valid, in_bits, in_last, word_ready,
        output word_valid, word_data, word_last
    );

endinterface

// File: rtl/in_chunks_chunk_fifo.sv
// Small word FIFO with wrap-bit pointers and a registered head (first-word fall-through).
module chunk_fifo #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_n;
    logic [PW-1:0] rd_ptr_n;
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  head_q;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    always_comb begin
        rd_ptr_n = rd_ptr + PW'(do_pop);
        wr_ptr_n = wr_ptr + PW'(do_push);
    end

    // Pointers and head register; head bypasses memory when the new head is being written now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            if (wr_ptr_n != rd_ptr_n) begin
                if (do_push && (rd_ptr_n == wr_ptr)) begin
                    head_q <= wr_data;
                end else begin
                    head_q <= mem[rd_ptr_n[AW-1:0]];
                end
            end
        end
    end

    // Storage array; every slot is written before it can become the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = head_q;

endmodule

// File: rtl/in_chunks.sv
// Assembles MS-first nibble chunks into words, queues them, and flags framing/overflow faults.
module in_chunks
    import in_chunks_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    in_chunks_if.slave  bus,
    output logic        frame_err,
    output logic        overflow
);

    localparam int unsigned CHUNKS = WORD_W / CHUNK_W;
    localparam int unsigned CNT_W  = cnt_width(CHUNKS);
    localparam int unsigned ENT_W  = WORD_W + 1;

    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] push_word;
    logic [ENT_W-1:0]  rd_entry;
    logic              word_end;
    logic              push_req;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bad_last;

    assign word_end  = (cnt == CNT_W'(CHUNKS - 1));
    assign push_req  = bus.in_valid & word_end;
    assign push_word = {asm_q[WORD_W-CHUNK_W-1:0], bus.in_bits};
    assign bad_last  = bus.in_valid & bus.in_last & ~word_end;
    assign pop       = ~fifo_empty & bus.word_ready;

    // Chunk counter and shift-in assembly register; a misplaced in_last realigns to a fresh word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            asm_q <= '0;
        end else if (bus.in_valid) begin
            if (word_end || bus.in_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (bad_last) begin
                asm_q <= '0;
            end else begin
                asm_q <= push_word;
            end
        end
    end

    // Sticky fault flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (bad_last) begin
                frame_err <= 1'b1;
            end
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    chunk_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_req),
        .wr_data ({bus.in_last, push_word}),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The last marker travels as the top bit of each FIFO entry.
    assign bus.word_valid = ~fifo_empty;
    assign bus.word_last  = rd_entry[WORD_W];
    assign bus.word_data  = rd_entry[WORD_W-1:0];

endmodule

// File: tb/tb_in_chunks.sv
// Directed self-checking bench for in_chunks (WORD_W=8, DEPTH=4).
module tb_in_chunks;

    logic clk;
    logic rst_n;
    logic frame_err;
    logic overflow;
    int   errors;
    int   checks;

    in_chunks_if #(.WORD_W(8)) bus ();

    in_chunks #(
        .WORD_W (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] b, input logic l);
        bus.in_valid = v;
        bus.in_bits  = b;
        bus.in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic l);
        step(1'b1, w[7:4], 1'b0);
        step(1'b1, w[3:0], l);
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_pulse_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_pulse_fe", 32'(frame_err), 32'h0);
        chk("rst_pulse_ovf", 32'(overflow), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_bits    = 4'hF;
        bus.in_last    = 1'b0;
        bus.word_ready = 1'b0;

        // Reset held with chunks arriving.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_data", 32'(bus.word_data), 32'h0);
        chk("rst_last", 32'(bus.word_last), 32'h0);
        chk("rst_fe", 32'(frame_err), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);

        // Release mid-stream: first chunk accepted, no word yet.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_no_push", 32'(bus.word_valid), 32'h0);
        // Reset mid-word drops the partial chunk silently.
        pulse_reset();

        // Word assembly with last marker.
        bus.word_ready = 1'b1;
        step(1'b1, 4'hA, 1'b0);
        chk("asm_half", 32'(bus.word_valid), 32'h0);
        step(1'b1, 4'h5, 1'b1);
        chk("asm_valid", 32'(bus.word_valid), 32'h1);
        chk("asm_data", 32'(bus.word_data), 32'hA5);
        chk("asm_last", 32'(bus.word_last), 32'h1);
        step(1'b0, 4'h0, 1'b0);
        chk("asm_popped", 32'(bus.word_valid), 32'h0);
        chk("asm_hold", 32'(bus.word_data), 32'hA5);

        // Gaps between chunks.
        step(1'b1, 4'h3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 1'b0);
            chk("gap_idle", 32'(bus.word_valid), 32'h0);
        end
        step(1'b1, 4'hC, 1'b0);
        chk("gap_valid", 32'(bus.word_valid), 32'h1);
        chk("gap_data", 32'(bus.word_data), 32'h3C);
        chk("gap_last", 32'(bus.word_last), 32'h0);
        step(1'b0, 4'h0, 1'b0);
        chk("gap_single", 32'(bus.word_valid), 32'h0);

        // Fill past capacity with no consumer.
        bus.word_ready = 1'b0;
        send_word(8'h11, 1'b0);
        chk("full_first", 32'(bus.word_data), 32'h11);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h44, 1'b0);
        chk("full_no_ovf", 32'(overflow), 32'h0);
        send_word(8'h55, 1'b0);
        chk("full_ovf", 32'(overflow), 32'h1);
        bus.word_ready = 1'b1;
        chk("drain_11", 32'(bus.word_data), 32'h11);
        step(1'b0, 4'h0, 1'b0);
        chk("drain_22", 32'(bus.word_data), 32'h22);
        step(1'b0, 4'h0, 1'b0);
        chk("drain_33", 32'(bus.word_data), 32'h33);
        step(1'b0, 4'h0, 1'b0);
        chk("drain_44", 32'(bus.word_data), 32'h44);
        chk("drain_44_v", 32'(bus.word_valid), 32'h1);
        step(1'b0, 4'h0, 1'b0);
        chk("drain_empty", 32'(bus.word_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Push and pop together while full.
        pulse_reset();
        chk("ovf_cleared", 32'(overflow), 32'h0);
        bus.word_ready = 1'b0;
        send_word(8'h61, 1'b0);
        send_word(8'h62, 1'b0);
        send_word(8'h63, 1'b0);
        send_word(8'h64, 1'b1);
        step(1'b1, 4'h6, 1'b0);
        bus.word_ready = 1'b1;
        step(1'b1, 4'h5, 1'b0);
        chk("pp_no_ovf", 32'(overflow), 32'h0);
        chk("pp_head", 32'(bus.word_data), 32'h62);
        step(1'b0, 4'h0, 1'b0);
        chk("pp_63", 32'(bus.word_data), 32'h63);
        step(1'b0, 4'h0, 1'b0);
        chk("pp_64", 32'(bus.word_data), 32'h64);
        chk("pp_64_last", 32'(bus.word_last), 32'h1);
        step(1'b0, 4'h0, 1'b0);
        chk("pp_65", 32'(bus.word_data), 32'h65);
        chk("pp_65_last", 32'(bus.word_last), 32'h0);
        step(1'b0, 4'h0, 1'b0);
        chk("pp_empty", 32'(bus.word_valid), 32'h0);
        chk("pp_ovf_end", 32'(overflow), 32'h0);

        // Framing error then realignment.
        step(1'b1, 4'h7, 1'b1);
        chk("fe_set", 32'(frame_err), 32'h1);
        chk("fe_no_word", 32'(bus.word_valid), 32'h0);
        step(1'b1, 4'h1, 1'b0);
        chk("fe_half", 32'(bus.word_valid), 32'h0);
        step(1'b1, 4'h2, 1'b0);
        chk("fe_realign_v", 32'(bus.word_valid), 32'h1);
        chk("fe_realign_d", 32'(bus.word_data), 32'h12);
        step(1'b0, 4'h0, 1'b0);
        chk("fe_sticky", 32'(frame_err), 32'h1);
        chk("fe_empty", 32'(bus.word_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
